// File: rtl/pc_pkg.sv
// Shared types, default vectors and the alignment helper used by the program-counter block.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam int          PC_INSTR_BYTES  = 4;
  localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VECTOR   = 32'h0000_0080;

  // True when the low log2(instr_bytes) bits of addr are zero (instr_bytes is a power of two).
  function automatic logic is_aligned(input logic [63:0] addr, input int unsigned instr_bytes);
    logic [63:0] mask;
    mask = 64'(instr_bytes) - 64'd1;
    return (addr & mask) == 64'd0;
  endfunction

endpackage

// File: rtl/pc_pending_reg.sv
// Holds one redirect target that arrived during a stall; the first captured target is kept.
module pc_pending_reg
  import pc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             clear,
  input  logic [WIDTH-1:0] target_in,
  output logic             valid,
  output logic [WIDTH-1:0] target
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture && !valid) begin
      valid <= 1'b1;
    end
  end

  // Target is only meaningful while valid is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture && !valid && !clear) begin
      target <= target_in;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: increments the PC, applies redirects and exceptions, buffers stalled redirects.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               INSTR_BYTES  = PC_INSTR_BYTES,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             exc_req,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             pc_valid,
  output logic             misalign_err,
  output logic [WIDTH-1:0] fetch_count
);

  pc_state_t        state_q, state_d;
  logic [WIDTH-1:0] pc_d;
  logic             pc_valid_d;
  logic             misalign_d;

  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic             pend_capture;
  logic             pend_clear;

  logic [WIDTH-1:0] apply_target;
  logic             apply_ok;

  pc_pending_reg #(
    .WIDTH(WIDTH)
  ) u_pending (
    .clk      (clk),
    .rst      (rst),
    .capture  (pend_capture),
    .clear    (pend_clear),
    .target_in(redirect_target),
    .valid    (pend_valid),
    .target   (pend_target)
  );

  assign pc_next_seq  = pc + WIDTH'(INSTR_BYTES);

  // A buffered redirect always beats a fresh one, so a single alignment check suffices.
  assign apply_target = pend_valid ? pend_target : redirect_target;
  assign apply_ok     = is_aligned(64'(apply_target), INSTR_BYTES);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc;
    pc_valid_d   = pc_valid;
    misalign_d   = 1'b0;
    pend_capture = 1'b0;
    pend_clear   = 1'b0;

    case (state_q)
      BOOT: begin
        pc_valid_d = 1'b1;
        state_d    = RUN;
      end

      RUN: begin
        if (exc_req) begin
          pc_d       = EXC_VECTOR;
          pend_clear = 1'b1;
        end else if (!stall && (pend_valid || redirect_valid)) begin
          pend_clear = pend_valid;
          if (apply_ok) begin
            pc_d = apply_target;
          end else begin
            pc_d       = EXC_VECTOR;
            misalign_d = 1'b1;
          end
        end else if (!stall && halt_req) begin
          pc_valid_d = 1'b0;
          state_d    = HALT;
        end else if (!stall) begin
          pc_d = pc_next_seq;
        end else if (redirect_valid) begin
          pend_capture = 1'b1;
        end
      end

      HALT: begin
        if (exc_req) begin
          pc_d       = EXC_VECTOR;
          pc_valid_d = 1'b1;
          pend_clear = 1'b1;
          state_d    = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= BOOT;
      pc           <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc           <= pc_d;
      pc_valid     <= pc_valid_d;
      misalign_err <= misalign_d;
    end
  end

  // Counts the outgoing fetch, independent of what the next PC turns out to be.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
    end else if (pc_valid && !stall) begin
      fetch_count <= fetch_count + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: 32-bit main instance plus an 8-bit instance for wrap and reset.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        rv;
  logic [31:0] rt;
  logic        ex;
  logic        ht;
  logic [31:0] pc;
  logic [31:0] nseq;
  logic        pv;
  logic        mis;
  logic [31:0] cnt;

  logic        rst8;
  logic        stall8;
  logic        rv8;
  logic [7:0]  rt8;
  logic        ex8;
  logic        ht8;
  logic [7:0]  pc8;
  logic [7:0]  nseq8;
  logic        pv8;
  logic        mis8;
  logic [7:0]  cnt8;

  typedef struct {
    bit          sel;
    logic [31:0] pc;
    logic        v;
    logic        m;
    logic [31:0] cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  pc_sequencer #(
    .WIDTH(32), .INSTR_BYTES(4), .RESET_VECTOR(32'h0), .EXC_VECTOR(32'h80)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(rv), .redirect_target(rt),
    .exc_req(ex), .halt_req(ht), .pc(pc), .pc_next_seq(nseq), .pc_valid(pv),
    .misalign_err(mis), .fetch_count(cnt)
  );

  pc_sequencer #(
    .WIDTH(8), .INSTR_BYTES(4), .RESET_VECTOR(8'hF8), .EXC_VECTOR(8'h80)
  ) dut8 (
    .clk(clk), .rst(rst8), .stall(stall8), .redirect_valid(rv8), .redirect_target(rt8),
    .exc_req(ex8), .halt_req(ht8), .pc(pc8), .pc_next_seq(nseq8), .pc_valid(pv8),
    .misalign_err(mis8), .fetch_count(cnt8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus for the 32-bit instance with the state expected after the edge.
  task automatic cyc(input logic s, input logic r, input logic [31:0] t, input logic e,
                     input logic h, input logic [31:0] epc, input logic ev, input logic em,
                     input logic [31:0] ecnt, input string nm);
    exp_t x;
    @(negedge clk);
    #1;
    stall = s; rv = r; rt = t; ex = e; ht = h;
    x.sel = 1'b0; x.pc = epc; x.v = ev; x.m = em; x.cnt = ecnt; x.name = nm;
    q.push_back(x);
  endtask

  task automatic cyc8(input logic [7:0] epc, input logic [7:0] ecnt, input string nm);
    exp_t x;
    @(negedge clk);
    #1;
    x.sel = 1'b1; x.pc = 32'(epc); x.v = 1'b1; x.m = 1'b0; x.cnt = 32'(ecnt); x.name = nm;
    q.push_back(x);
  endtask

  task automatic drain();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  // Monitor: compares every output of the selected instance once per clock while work is queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.sel) begin
          chk({e.name, ".pc"},   pc,  e.pc);
          chk({e.name, ".nseq"}, nseq, e.pc + 32'd4);
          chk({e.name, ".pv"},   32'(pv),  32'(e.v));
          chk({e.name, ".mis"},  32'(mis), 32'(e.m));
          chk({e.name, ".cnt"},  cnt, e.cnt);
        end else begin
          chk({e.name, ".pc8"},   32'(pc8),   e.pc);
          chk({e.name, ".nseq8"}, 32'(nseq8), 32'(8'(e.pc[7:0] + 8'd4)));
          chk({e.name, ".pv8"},   32'(pv8),   32'(e.v));
          chk({e.name, ".cnt8"},  32'(cnt8),  e.cnt);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rst8 = 1'b1;
    stall = 1'b0; rv = 1'b0; rt = 32'h0; ex = 1'b0; ht = 1'b0;
    stall8 = 1'b0; rv8 = 1'b0; rt8 = 8'h0; ex8 = 1'b0; ht8 = 1'b0;
    #1;
    rst = 1'b0; rst8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("rst.pc", pc, 32'h0);
    chk("rst.pv", 32'(pv), 32'd0);
    chk("rst.mis", 32'(mis), 32'd0);
    chk("rst.cnt", cnt, 32'd0);
    chk("rst.pc8", 32'(pc8), 32'hF8);
    chk("rst.pv8", 32'(pv8), 32'd0);

    rst = 1'b1;
    #1;
    chk("boot.pc", pc, 32'h0);
    chk("boot.pv", 32'(pv), 32'd0);

    //   stall rv rt          exc halt  pc           v     m     cnt
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h00,  1'b1, 1'b0, 32'd0,  "boot");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h04,  1'b1, 1'b0, 32'd1,  "inc1");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h08,  1'b1, 1'b0, 32'd2,  "inc2");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0C,  1'b1, 1'b0, 32'd3,  "inc3");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 1'b0, 32'd4,  "inc4");
    cyc(1'b1, 1'b1, 32'h40,  1'b0, 1'b0, 32'h10,  1'b1, 1'b0, 32'd4,  "stall1");
    cyc(1'b1, 1'b1, 32'h80,  1'b0, 1'b0, 32'h10,  1'b1, 1'b0, 32'd4,  "stall2");
    cyc(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h10,  1'b1, 1'b0, 32'd4,  "stall3");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h40,  1'b1, 1'b0, 32'd5,  "pend_apply");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h44,  1'b1, 1'b0, 32'd6,  "after_pend");
    cyc(1'b0, 1'b1, 32'h42,  1'b0, 1'b0, 32'h80,  1'b1, 1'b1, 32'd7,  "misalign");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h84,  1'b1, 1'b0, 32'd8,  "mis_pulse_end");
    cyc(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80,  1'b1, 1'b0, 32'd8,  "prio_exc");
    cyc(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h80,  1'b1, 1'b0, 32'd8,  "prio_hold");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h84,  1'b1, 1'b0, 32'd9,  "prio_no_pend");
    cyc(1'b1, 1'b1, 32'h202, 1'b0, 1'b0, 32'h84,  1'b1, 1'b0, 32'd9,  "pend_mis_cap");
    cyc(1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 32'h80,  1'b1, 1'b1, 32'd10, "pend_mis_apply");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h84,  1'b1, 1'b0, 32'd11, "drop_check");
    cyc(1'b0, 1'b1, 32'h18,  1'b0, 1'b0, 32'h18,  1'b1, 1'b0, 32'd12, "redir18");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h1C,  1'b1, 1'b0, 32'd13, "inc1c");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h20,  1'b1, 1'b0, 32'd14, "inc20");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h20,  1'b0, 1'b0, 32'd15, "halt");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h20,  1'b0, 1'b0, 32'd15, "halt_hold");
    cyc(1'b0, 1'b1, 32'h40,  1'b0, 1'b1, 32'h20,  1'b0, 1'b0, 32'd15, "halt_ignore");
    cyc(1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 32'h80,  1'b1, 1'b0, 32'd15, "resume_exc");
    cyc(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h84,  1'b1, 1'b0, 32'd16, "resume_inc");
    @(negedge clk);
    #1;
    stall = 1'b0; rv = 1'b0; rt = 32'h0; ex = 1'b0; ht = 1'b0;
    drain();

    @(posedge clk);
    #2;
    rst8 = 1'b1;
    #1;
    chk("boot8.pc8", 32'(pc8), 32'hF8);
    chk("boot8.pv8", 32'(pv8), 32'd0);
    cyc8(8'hF8, 8'd0, "w_boot");
    cyc8(8'hFC, 8'd1, "w_fc");
    cyc8(8'h00, 8'd2, "w_wrap");
    cyc8(8'h04, 8'd3, "w_04");
    drain();

    @(posedge clk);
    #3;
    rst8 = 1'b0;
    rst  = 1'b0;
    #1;
    chk("async.pc8",  32'(pc8),  32'hF8);
    chk("async.pv8",  32'(pv8),  32'd0);
    chk("async.mis8", 32'(mis8), 32'd0);
    chk("async.cnt8", 32'(cnt8), 32'd0);
    chk("async.pc",   pc,  32'h0);
    chk("async.pv",   32'(pv),  32'd0);
    chk("async.cnt",  cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised successor to the datapath's program counter. It holds the fetch address for instruction memory and advances it by one instruction per cycle. It also handles the pipeline's control inputs: hazard stall, branch/jump redirect (buffered when it arrives during a stall), exception vectoring, misaligned-target detection and halt. It sits at the head of the IF stage, drives the instruction-memory address and the IF/ID PC+4 field, and takes its control inputs from the hazard unit and from the EX/MEM branch/jump logic.

## Interface
- WIDTH, 32: PC and counter width in bits.
- INSTR_BYTES, 4: increment per instruction; must be a power of two.
- RESET_VECTOR, 32'h0000_0000: PC value during and after reset.
- EXC_VECTOR, 32'h0000_0080: PC loaded on exception or misaligned redirect.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- stall  in  1  hazard stall; hold the PC.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  WIDTH  target address.
- exc_req  in  1  exception request; highest priority.
- halt_req  in  1  stop fetching.
- pc  out  WIDTH  current fetch address (registered).
- pc_next_seq  out  WIDTH  pc + INSTR_BYTES (combinational from pc).
- pc_valid  out  1  pc is a real fetch (registered).
- misalign_err  out  1  one-cycle pulse on misaligned redirect (registered).
- fetch_count  out  WIDTH  count of accepted fetches (registered).

## Operation
- Reset (rst low, asynchronous) sets the following values:
  - pc = RESET_VECTOR
  - pc_valid = 0
  - misalign_err = 0
  - fetch_count = 0
  - pending redirect cleared
  - state = BOOT
- States: BOOT, RUN, HALT.
- BOOT: first clock after rst rises. Set pc_valid = 1 and move to RUN. pc holds RESET_VECTOR. All other inputs are ignored.
- RUN, evaluated each cycle in priority order:
  1. exc_req: pc ← EXC_VECTOR, pending cleared, stall ignored.
  2. Not stalled and a pending redirect exists: pc ← pending target, pending cleared. A redirect_valid in that same cycle is dropped.
  3. Not stalled and redirect_valid: pc ← redirect_target.
  4. Not stalled and halt_req: pc holds, pc_valid ← 0, go to HALT.
  5. Not stalled otherwise: pc ← pc + INSTR_BYTES.
  6. Stalled: pc holds. If redirect_valid and no pending redirect exists, capture the target into pending. If one already exists, keep the first one (older instruction wins).
- Misalignment: any applied target with nonzero low log2(INSTR_BYTES) bits loads EXC_VECTOR instead and pulses misalign_err for one cycle. This covers both direct and pending targets.
- HALT: pc and pc_valid = 0 hold. Only exc_req (→ RUN, pc ← EXC_VECTOR, pc_valid ← 1) or reset leaves HALT.
- fetch_count increments by 1 on every clock where pc_valid = 1 and stall = 0. It increments for the outgoing pc, before exception or redirect handling.
- Arithmetic: pc + INSTR_BYTES and fetch_count both wrap modulo 2^WIDTH with no flag.

## Timing
- Every registered output takes effect on the rising edge following its causing input. Redirect, exception and increment latency is 1 cycle.
- Pending redirect applies on the first edge where stall = 0. pc shows the target one cycle after stall drops.
- pc_next_seq has zero latency from pc.
- Reset asserted mid-operation drops all outputs to their reset values immediately, without waiting for the clock. A stall or pending redirect in progress at that moment is lost.
- exc_req and redirect_valid in the same cycle: exception wins and the redirect is discarded.

## Structure
- Shared package pc_pkg holds the following:
  - pc_state_t enum (BOOT, RUN, HALT)
  - default INSTR_BYTES
  - default RESET_VECTOR and EXC_VECTOR
  - an alignment-check function
- One sub-module, pc_pending_reg: a valid + target register with capture, first-wins and clear inputs. The same asynchronous active-low reset clears it.

## Test plan
- Reset release: hold rst low, then raise it. Required: pc = 0x0 and pc_valid = 0 for the BOOT cycle. Then pc_valid = 1 and pc steps 0x0, 0x4, 0x8 on the following clocks. fetch_count = 3 after three unstalled cycles.
- Stall plus redirect: at pc = 0x10, assert stall for 3 cycles with redirect 0x40 on stall cycle 1 and 0x80 on stall cycle 2. Required: pc holds 0x10 during the stall, becomes 0x40 one cycle after stall drops, and 0x80 never appears.
- Misaligned redirect: redirect_target = 0x42 while running. Required: next pc = 0x80 (EXC_VECTOR) and misalign_err high for exactly 1 cycle.
- Priority: exc_req, redirect_valid (0x100) and stall all high in the same cycle. Required: next pc = 0x80 and the pending redirect stays empty.
- Halt and resume: halt_req at pc = 0x20. Required: pc_valid = 0, pc frozen at 0x20, fetch_count frozen. Then exc_req gives pc = 0x80 and pc_valid = 1.
- Wrap and async reset: set WIDTH = 8 and run from 0xF8 to 0xFC to 0x00. Then drop rst between clock edges. Required: outputs return to reset values before the next edge.
